// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, state encoding and lane helper for the Kyber dout reorder stage
package kyber_pkg;
    localparam int PE_NUMBER = 4;
    localparam int W = 12;
    localparam int N = 256;
    localparam int BEATS = N / PE_NUMBER;
    localparam logic [W-1:0] Q = W'(3329);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;
    function automatic logic [W-1:0] lane(input logic [PE_NUMBER*W-1:0] w, input int k);
        return w[W*(PE_NUMBER-1-k) +: W];
    endfunction
endpackage

// File: rtl/kyber_coef_bank.sv
// kyber_coef_bank: 128x12 register file, two writes at 2b/2b+1, one 4-coefficient read at 4j
import kyber_pkg::*;
module kyber_coef_bank (
    input  logic                    clk,
    input  logic                    we,
    input  logic [5:0]              waddr,
    input  logic [W-1:0]            wd0,
    input  logic [W-1:0]            wd1,
    input  logic [4:0]              raddr,
    output logic [PE_NUMBER*W-1:0]  rdata
);
    logic [W-1:0] mem [N/2];
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{waddr, 1'b0}] <= wd0;
            mem[{waddr, 1'b1}] <= wd1;
        end
    end
    assign rdata = {mem[{raddr, 2'd0}], mem[{raddr, 2'd1}], mem[{raddr, 2'd2}], mem[{raddr, 2'd3}]};
endmodule

// File: rtl/kyber_dout_reorder.sv
// kyber_dout_reorder: buffers a half-interleaved 64-beat burst and replays it in natural order
import kyber_pkg::*;
module kyber_dout_reorder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [47:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic        out_last,
    output logic        done,
    output logic        err_range
);
    state_t      state;
    logic [5:0]  wr_cnt;
    logic [5:0]  rd_cnt;
    logic        bad;
    logic        we;
    logic [47:0] lo_rd;
    logic [47:0] hi_rd;
    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < PE_NUMBER; k++) bad = bad | (lane(in_data, k) >= Q);
    end
    assign in_ready  = state != DRAIN;
    assign out_valid = state == DRAIN;
    assign out_last  = out_valid && rd_cnt == 6'(BEATS-1);
    assign we        = in_valid && in_ready;
    assign out_data  = rd_cnt[5] ? hi_rd : lo_rd;
    kyber_coef_bank lo (
        .clk(clk), .we(we), .waddr(wr_cnt), .wd0(lane(in_data, 0)), .wd1(lane(in_data, 2)),
        .raddr(rd_cnt[4:0]), .rdata(lo_rd)
    );
    kyber_coef_bank hi (
        .clk(clk), .we(we), .waddr(wr_cnt), .wd0(lane(in_data, 1)), .wd1(lane(in_data, 3)),
        .raddr(rd_cnt[4:0]), .rdata(hi_rd)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_range <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    err_range <= bad;
                    wr_cnt    <= 6'd1;
                    state     <= FILL;
                end
                FILL: if (in_valid) begin
                    err_range <= err_range | bad;
                    wr_cnt    <= wr_cnt + 6'd1;
                    if (wr_cnt == 6'(BEATS-1)) state <= DRAIN;
                end
                DRAIN: if (out_ready) begin
                    rd_cnt <= rd_cnt + 6'd1;
                    if (rd_cnt == 6'(BEATS-1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kyber_dout_reorder.sv
// tb_kyber_dout_reorder: randomized self-checking bench against a natural-order reference model
module tb_kyber_dout_reorder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [47:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_last, done, err_range;
    logic [47:0] out_data;
    int checks = 0;
    int failures = 0;
    logic [11:0] cbuf [256];
    logic [47:0] in_q[$];
    logic [47:0] exp_q[$];
    bit          bad_q[$];
    logic [47:0] got [64];
    bit draining = 0, err_m = 0, done_exp = 0;
    int acc = 0, outn = 0, in_tot = 0, out_tot = 0;

    kyber_dout_reorder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got_v, input logic [47:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic push_burst();
        for (int b = 0; b < 64; b++) begin
            in_q.push_back({cbuf[2*b], cbuf[2*b+128], cbuf[2*b+1], cbuf[2*b+129]});
            bad_q.push_back(cbuf[2*b] >= 3329 || cbuf[2*b+128] >= 3329 ||
                            cbuf[2*b+1] >= 3329 || cbuf[2*b+129] >= 3329);
        end
        for (int j = 0; j < 64; j++)
            exp_q.push_back({cbuf[4*j], cbuf[4*j+1], cbuf[4*j+2], cbuf[4*j+3]});
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) cbuf[i] = 12'($urandom_range(0, 3328));
    endtask

    task automatic run(input int gap, input int bp, input int stop_in, input int stop_out);
        int cyc;
        bit stalled, hs_i, hs_o, bd;
        logic [47:0] prev;
        stalled = 0;
        prev = '0;
        in_tot = 0;
        out_tot = 0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            chk("in_ready", 48'(in_ready), 48'(!draining));
            chk("out_valid", 48'(out_valid), 48'(draining));
            chk("done", 48'(done), 48'(done_exp));
            chk("err_range", 48'(err_range), 48'(err_m));
            if (draining && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", 48'(out_last), 48'(outn == 63));
                if (stalled) chk("stall_hold", out_data, prev);
            end
            done_exp = 0;
            if (exp_q.size() == 0 || in_tot >= stop_in || out_tot >= stop_out) break;
            in_valid = in_q.size() > 0 && (cyc % gap == 0);
            in_data = in_valid ? in_q[0] : {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            out_ready = bp == 0 ? 1'b1 : bp == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            hs_i = in_valid && !draining;
            hs_o = draining && out_ready;
            stalled = draining && !out_ready;
            prev = out_data;
            if (hs_i) begin
                bd = bad_q.pop_front();
                void'(in_q.pop_front());
                err_m = acc == 0 ? bd : (err_m | bd);
                acc++;
                in_tot++;
                if (acc == 64) begin
                    acc = 0;
                    draining = 1;
                end
            end
            if (hs_o) begin
                got[outn] = out_data;
                void'(exp_q.pop_front());
                outn++;
                out_tot++;
                if (outn == 64) begin
                    outn = 0;
                    draining = 0;
                    done_exp = 1;
                end
            end
        end
        if (cyc == 4000) chk("timeout", 48'(cyc), 48'(0));
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        bad_q.delete();
        draining = 0;
        err_m = 0;
        done_exp = 0;
        acc = 0;
        outn = 0;
        chk("rst_in_ready", 48'(in_ready), 48'(1));
        chk("rst_out_valid", 48'(out_valid), 48'(0));
        chk("rst_out_last", 48'(out_last), 48'(0));
        chk("rst_done", 48'(done), 48'(0));
        chk("rst_err", 48'(err_range), 48'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 256; i++) cbuf[i] = 12'(i);
        push_burst();
        run(1, 0, 1 << 30, 1 << 30);
        chk("nat_beat0", got[0], 48'h000_001_002_003);
        chk("nat_beat32", got[32], 48'h080_081_082_083);
        chk("nat_beat63", got[63], 48'h0FC_0FD_0FE_0FF);
        chk("nat_err", 48'(err_range), 48'(0));
        push_burst();
        run(1, 1, 1 << 30, 1 << 30);
        chk("bp_handshakes", 48'(out_tot), 48'(64));
        chk("bp_beat63", got[63], 48'h0FC_0FD_0FE_0FF);
        fill_rand();
        cbuf[35] = 12'hD01;
        push_burst();
        run(1, 2, 1 << 30, 1 << 30);
        chk("range_sticky", 48'(err_range), 48'(1));
        fill_rand();
        push_burst();
        run(1, 2, 1 << 30, 1 << 30);
        chk("range_cleared", 48'(err_range), 48'(0));
        for (int i = 0; i < 256; i++) cbuf[i] = 12'(i);
        push_burst();
        run(3, 0, 1 << 30, 1 << 30);
        chk("gap_beat32", got[32], 48'h080_081_082_083);
        push_burst();
        run(1, 0, 40, 1 << 30);
        do_reset();
        for (int i = 0; i < 256; i++) cbuf[i] = 12'(255 - i);
        push_burst();
        run(1, 0, 1 << 30, 1 << 30);
        chk("rst_new_beat0", got[0], 48'h0FF_0FE_0FD_0FC);
        push_burst();
        run(1, 0, 1 << 30, 20);
        do_reset();
        fill_rand();
        push_burst();
        fill_rand();
        cbuf[200] = 12'hFFF;
        push_burst();
        run(1, 0, 1 << 30, 1 << 30);
        chk("b2b_drained", 48'(exp_q.size()), 48'(0));
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            if ($urandom_range(0, 1) == 1) cbuf[$urandom_range(0, 255)] = 12'($urandom_range(3329, 4095));
            push_burst();
            run($urandom_range(1, 3), 2, 1 << 30, 1 << 30);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kyber_dout_reorder.md
Name: kyber_dout_reorder

Overview:
- Downstream unload stage for the 4-PE Kyber half-polynomial multiplier core.
- Captures the 64-beat, 48-bit result burst the core emits after read_a, which arrives in half-interleaved order (m, m+128, m+1, m+129).
- Buffers all 256 coefficients, range-checks each one against q, then streams them back out in natural order (4j..4j+3 per beat) over a valid/ready interface to the host or packer.

Parameters:
- PE_NUMBER, 4, coefficients per beat. Only 4 is supported.
- W, 12, coefficient width in bits.
- N, 256, coefficients per polynomial.
- Q, 3329, Kyber modulus used for the range check.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid. The core's dout burst is qualified by this signal.
- in_data  in  48  packed input beat: [47:36]=c[2b], [35:24]=c[2b+128], [23:12]=c[2b+1], [11:0]=c[2b+129], where b is the beat index 0..63.
- in_ready  out  1  high in IDLE and FILL.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the output beat.
- out_data  out  48  {c[4j], c[4j+1], c[4j+2], c[4j+3]}, with c[4j] in the MSBs; j is the output beat index 0..63.
- out_last  out  1  high with out_valid on beat j=63.
- done  out  1  one-cycle pulse in the cycle after the j=63 handshake.
- err_range  out  1  sticky: set when any captured coefficient is >= Q. Cleared by reset or by the first beat of a new FILL.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_last=0, done=0, err_range=0, state=IDLE, wr_cnt=0, rd_cnt=0. Buffer contents are not cleared; they are unobservable while out_valid=0.
- Reset asserted in any state, including mid-FILL or mid-DRAIN, returns to the reset values on the next edge. Any partial burst is discarded.
- State machine IDLE -> FILL -> DRAIN -> IDLE.
  - IDLE: an in_valid beat is written as b=0, err_range is recomputed from this beat only, wr_cnt becomes 1, and the state moves to FILL.
  - FILL: each in_valid beat is written at b=wr_cnt and wr_cnt increments. Gaps in in_valid are allowed. On the beat with b=63, the state moves to DRAIN next cycle and wr_cnt wraps to 0.
  - DRAIN: in_ready=0 and in_valid is ignored. The core must not be read during DRAIN.
    - out_valid=1 from the first DRAIN cycle.
    - out_data is read combinationally from the buffer at rd_cnt.
    - On out_valid && out_ready, rd_cnt increments. With out_ready held high, throughput is 1 beat per cycle.
    - While out_ready=0, out_data and out_last are held stable.
    - The j=63 handshake moves to IDLE, rd_cnt wraps to 0, and done pulses for 1 cycle.
- Write mapping for beat b:
  - lower bank: lo[2b] and lo[2b+1] get c[2b] and c[2b+1].
  - upper bank: hi[2b] and hi[2b+1] get c[2b+128] and c[2b+129].
- Read mapping for j<32: lo[4j..4j+3]. For j>=32: hi[4(j-32)..4(j-32)+3].
- Latency: the first output beat is valid 1 cycle after the b=63 input beat.
- Range check: compare each of the 4 lanes to Q, unsigned 12-bit. The four results are OR-reduced into err_range on the write cycle.
- Pipeline handover: in_valid asserted in the same cycle as the final out handshake is not accepted (in_ready=0). It is accepted from the next cycle.

Decomposition:
- Shared package kyber_pkg holds:
  - constants W, N, Q, PE_NUMBER, BEATS=N/PE_NUMBER;
  - a localparam enum for the state encoding (IDLE=0, FILL=1, DRAIN=2);
  - a lane-slicing function that returns lane k of a 48-bit word.
- One natural sub-module, kyber_coef_bank: a 128x12 register file with 2 write ports (addresses 2b, 2b+1) and 1 wide 4-coefficient read port. It is instantiated twice, as lo and hi.

Test Plan:
- Natural stream: feed c[i]=i for all 256 in interleaved order with out_ready=1.
  - Beat 0 must be 0x000_001_002_003, beat 32 must be 0x080_081_082_083, and beat 63 must be 0x0FC_0FD_0FE_0FF.
  - out_last is high on beat 63, done pulses once, and err_range=0.
- Backpressure: same data with out_ready toggling 1,0,0,1,...
  - out_data is stable across stalls, exactly 64 handshakes occur, and the order is identical to the natural-stream case.
- Range error: beat 17 lane 2 = 0xD01 (3329), all others valid.
  - err_range=1 after that beat and stays 1 through DRAIN.
  - A new clean burst clears it on its first beat.
- Gapped input: in_valid active every 3rd cycle.
  - DRAIN starts exactly 1 cycle after the 64th valid beat; output matches the natural-stream case.
- Reset mid-operation: reset asserted after 40 input beats, then a full new burst of c[i]=255-i.
  - Output beat 0 = 0x0FF_0FE_0FD_0FC, with no stale data.
  - Repeat with reset asserted at output beat 20: out_valid=0 the next cycle.
- Back-to-back bursts: in_valid held high across the final out handshake.
  - The overlapping beat is not accepted (in_ready=0), the second burst starts the cycle after, and both output streams are correct.
